// File: rtl/fifo_ecc_pkg.sv
// Shared definitions for fifo_with_sm: default sizing, codeword width,
// Hamming encode/syndrome/decode helpers and the safety-monitor state type.
// Codeword layout: position p (1..ECC_WIDTH) lives in bit p-1; check bits sit
// at positions 1,2,4,..,64 and data bits fill the remaining positions ascending.
package fifo_ecc_pkg;

    localparam int unsigned DEF_FIFO_DEPTH   = 128;
    localparam int unsigned DEF_DATA_WIDTH   = 64;
    localparam int unsigned DEF_PARITY_WIDTH = 7;
    localparam int unsigned ECC_WIDTH        = DEF_DATA_WIDTH + DEF_PARITY_WIDTH;

    localparam int unsigned DIDX_W = $clog2(DEF_DATA_WIDTH);
    localparam int unsigned CIDX_W = $clog2(ECC_WIDTH);
    localparam int unsigned PIDX_W = $clog2(DEF_PARITY_WIDTH);

    typedef enum logic {
        SM_OK    = 1'b0,
        SM_FAULT = 1'b1
    } sm_state_t;

    // Result of the most recent accepted read.
    typedef struct packed {
        logic [DEF_PARITY_WIDTH-1:0] syndrome;
        logic                        correct;
        logic                        error;
    } ecc_status_t;

    // Powers of two are check-bit positions.
    function automatic logic is_check_pos(input int unsigned pos);
        return (pos & (pos - 32'd1)) == 32'd0;
    endfunction

    function automatic logic [ECC_WIDTH-1:0] ecc_encode(input logic [DEF_DATA_WIDTH-1:0] data);
        logic [ECC_WIDTH-1:0] cw;
        int unsigned          k;
        logic                 p;
        cw = '0;
        k  = 0;
        for (int unsigned pos = 1; pos <= ECC_WIDTH; pos++) begin
            if (!is_check_pos(pos)) begin
                cw[CIDX_W'(pos - 32'd1)] = data[DIDX_W'(k)];
                k++;
            end
        end
        for (int unsigned j = 0; j < DEF_PARITY_WIDTH; j++) begin
            p = 1'b0;
            for (int unsigned pos = 1; pos <= ECC_WIDTH; pos++) begin
                if (((pos >> j) & 32'd1) != 32'd0) p = p ^ cw[CIDX_W'(pos - 32'd1)];
            end
            cw[CIDX_W'((32'd1 << j) - 32'd1)] = p;
        end
        return cw;
    endfunction

    // XOR over every covered position including the check bit itself equals
    // recomputed check bits XOR stored check bits.
    function automatic logic [DEF_PARITY_WIDTH-1:0] ecc_syndrome(input logic [ECC_WIDTH-1:0] cw);
        logic [DEF_PARITY_WIDTH-1:0] s;
        s = '0;
        for (int unsigned j = 0; j < DEF_PARITY_WIDTH; j++) begin
            for (int unsigned pos = 1; pos <= ECC_WIDTH; pos++) begin
                if (((pos >> j) & 32'd1) != 32'd0)
                    s[PIDX_W'(j)] = s[PIDX_W'(j)] ^ cw[CIDX_W'(pos - 32'd1)];
            end
        end
        return s;
    endfunction

    function automatic logic [DEF_DATA_WIDTH-1:0] ecc_decode(input logic [ECC_WIDTH-1:0] cw);
        logic [DEF_DATA_WIDTH-1:0] d;
        int unsigned               k;
        d = '0;
        k = 0;
        for (int unsigned pos = 1; pos <= ECC_WIDTH; pos++) begin
            if (!is_check_pos(pos)) begin
                d[DIDX_W'(k)] = cw[CIDX_W'(pos - 32'd1)];
                k++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/fifo_with_sm_if.sv
// FIFO data/flag bundle.
// slave : the FIFO (takes WriteEn/DataIn/ReadEn, drives data, flags, ECC, errors)
// master: the user of the FIFO.
interface fifo_with_sm_if
    import fifo_ecc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned PARITY_WIDTH = DEF_PARITY_WIDTH
);
    logic                    WriteEn;
    logic [DATA_WIDTH-1:0]   DataIn;
    logic                    ReadEn;
    logic [DATA_WIDTH-1:0]   DataOut;
    logic                    Empty_;
    logic                    HalfFull_;
    logic                    Full_;
    logic                    error_flag;
    logic [PARITY_WIDTH-1:0] is_parity_diff;
    logic                    correct;
    logic                    sm_error;
    logic                    Error;

    modport master (
        output WriteEn, DataIn, ReadEn,
        input  DataOut, Empty_, HalfFull_, Full_, error_flag,
               is_parity_diff, correct, sm_error, Error
    );

    modport slave (
        input  WriteEn, DataIn, ReadEn,
        output DataOut, Empty_, HalfFull_, Full_, error_flag,
               is_parity_diff, correct, sm_error, Error
    );
endinterface

// File: rtl/fifo_safety_monitor.sv
// Independent FIFO occupancy tracker that cross-checks the published flags.
// Ports: Clock, Reset_ (sync, active-high); i_write_en/i_read_en requests;
// i_empty_n/i_half_full_n/i_full_n flags under check; o_sm_error sticky fault.
module fifo_safety_monitor
    import fifo_ecc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic Clock,
    input  logic Reset_,
    input  logic i_write_en,
    input  logic i_read_en,
    input  logic i_empty_n,
    input  logic i_half_full_n,
    input  logic i_full_n,
    output logic o_sm_error
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    sm_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_shadow, w_shadow_nxt;
    logic             w_sh_full, w_sh_empty, w_sh_rd, w_sh_wr, w_check_fail;

    assign w_sh_full  = (r_shadow == CNT_W'(FIFO_DEPTH));
    assign w_sh_empty = (r_shadow == '0);
    assign w_sh_rd    = i_read_en && !w_sh_empty;
    assign w_sh_wr    = i_write_en && (!w_sh_full || w_sh_rd);

    assign w_check_fail = (!i_empty_n && !i_full_n)
                       || (i_empty_n != !w_sh_empty)
                       || (i_full_n != !w_sh_full)
                       || (i_half_full_n != (r_shadow < CNT_W'(FIFO_DEPTH / 2)));

    // State and shadow count registers.
    always_ff @(posedge Clock) begin
        if (Reset_) begin
            r_state  <= SM_OK;
            r_shadow <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
        end
    end

    // Next shadow count and fault latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        if (w_sh_wr && !w_sh_rd) w_shadow_nxt = r_shadow + CNT_W'(1);
        if (w_sh_rd && !w_sh_wr) w_shadow_nxt = r_shadow - CNT_W'(1);
        case (r_state)
            SM_OK:    if (w_check_fail) w_state_nxt = SM_FAULT;
            SM_FAULT: w_state_nxt = SM_FAULT;
            default:  w_state_nxt = SM_FAULT;
        endcase
    end

    assign o_sm_error = (r_state == SM_FAULT);

endmodule

// File: rtl/fifo_with_sm.sv
// Hamming-protected synchronous FIFO with a safety monitor.
// Ports: Clock, Reset_ (sync, active-high), bus (slave side of fifo_with_sm_if):
// WriteEn/DataIn/ReadEn in; DataOut, Empty_/HalfFull_/Full_ (active-low),
// error_flag, is_parity_diff, correct, sm_error, Error out.
// DATA_WIDTH/PARITY_WIDTH must match the package, which sizes the ECC helpers.
module fifo_with_sm
    import fifo_ecc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned PARITY_WIDTH = DEF_PARITY_WIDTH
) (
    input  logic          Clock,
    input  logic          Reset_,
    fifo_with_sm_if.slave bus
);
    localparam int unsigned ECC_W = DATA_WIDTH + PARITY_WIDTH;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ECC_W-1:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]        r_count, w_count_nxt;
    logic                    r_empty_n, r_half_n, r_full_n;
    logic [DATA_WIDTH-1:0]   r_dout;
    ecc_status_t             r_status;

    logic                    w_full, w_empty, w_wr_acc, w_rd_acc;
    logic [ECC_W-1:0]        w_rd_cw, w_fixed_cw;
    logic [PARITY_WIDTH-1:0] w_syn;
    logic                    w_corr_en, w_uncorr, w_sm_error;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = bus.ReadEn && !w_empty;
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign w_wr_acc = bus.WriteEn && (!w_full || w_rd_acc);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) w_count_nxt = r_count + CNT_W'(1);
        if (w_rd_acc && !w_wr_acc) w_count_nxt = r_count - CNT_W'(1);
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge Clock) begin
        if (!Reset_ && w_wr_acc) r_mem[r_wr_ptr] <= ecc_encode(bus.DataIn);
    end

    // Head-of-queue decode: a nonzero in-range syndrome names the flipped position.
    assign w_rd_cw    = r_mem[r_rd_ptr];
    assign w_syn      = ecc_syndrome(w_rd_cw);
    assign w_corr_en  = (w_syn != '0) && (32'(w_syn) <= ECC_W);
    assign w_uncorr   = (32'(w_syn) > ECC_W);
    assign w_fixed_cw = w_corr_en ? (w_rd_cw ^ (ECC_W'(1) << (w_syn - PARITY_WIDTH'(1)))) : w_rd_cw;
    assign w_rd_data  = ecc_decode(w_fixed_cw);

    // Pointers, count, flags and read-side registers.
    always_ff @(posedge Clock) begin
        if (Reset_) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_empty_n <= 1'b0;
            r_half_n  <= 1'b1;
            r_full_n  <= 1'b1;
            r_dout    <= '0;
            r_status  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd_acc) begin
                r_rd_ptr         <= r_rd_ptr + PTR_W'(1);
                r_dout           <= w_rd_data;
                r_status.syndrome <= w_syn;
                r_status.correct  <= w_corr_en;
                r_status.error    <= w_uncorr;
            end
            r_count   <= w_count_nxt;
            r_empty_n <= (w_count_nxt != '0);
            r_half_n  <= (w_count_nxt < CNT_W'(FIFO_DEPTH / 2));
            r_full_n  <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    // The monitor watches the flags as published on the bus.
    fifo_safety_monitor #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_sm (
        .Clock         (Clock),
        .Reset_        (Reset_),
        .i_write_en    (bus.WriteEn),
        .i_read_en     (bus.ReadEn),
        .i_empty_n     (bus.Empty_),
        .i_half_full_n (bus.HalfFull_),
        .i_full_n      (bus.Full_),
        .o_sm_error    (w_sm_error)
    );

    assign bus.DataOut        = r_dout;
    assign bus.Empty_         = r_empty_n;
    assign bus.HalfFull_      = r_half_n;
    assign bus.Full_          = r_full_n;
    assign bus.error_flag     = r_status.error;
    assign bus.is_parity_diff = r_status.syndrome;
    assign bus.correct        = r_status.correct;
    assign bus.sm_error       = w_sm_error;
    assign bus.Error          = r_status.error | w_sm_error;

endmodule

// File: tb/tb_fifo_with_sm.sv
// Directed bench for fifo_with_sm: vector table for basic traffic plus
// sequences for fill/drain, full-FIFO streaming, ECC injection and the monitor.
module tb_fifo_with_sm;
    import fifo_ecc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fifo_with_sm_if u_if ();

    fifo_with_sm dut (
        .Clock  (clk),
        .Reset_ (rst),
        .bus    (u_if.slave)
    );

    typedef struct {
        logic        we;
        logic        re;
        logic [63:0] din;
        logic [2:0]  flags;   // {Empty_, HalfFull_, Full_}
        logic [63:0] dout;
    } vec_t;

    localparam logic [63:0] VA = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] VB = 64'hFFFF_0000_FFFF_0000;
    localparam logic [63:0] VC = 64'hAAAA_5555_AAAA_5555;
    localparam logic [63:0] VD = 64'h8000_0000_0000_0001;

    vec_t vecs [9];
    logic [ECC_WIDTH-1:0] cw;
    logic [ECC_WIDTH-1:0] mask;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        u_if.WriteEn = 1'b0;
        u_if.ReadEn  = 1'b0;
        u_if.DataIn  = '0;
    endtask

    // Requests held high during reset must be ignored.
    task automatic do_reset();
        rst          = 1'b1;
        u_if.WriteEn = 1'b1;
        u_if.ReadEn  = 1'b1;
        u_if.DataIn  = 64'h0000_0000_0000_0BAD;
        tick();
        tick();
        rst = 1'b0;
        idle();
    endtask

    task automatic write_one(input logic [63:0] d);
        u_if.WriteEn = 1'b1;
        u_if.DataIn  = d;
        tick();
        idle();
    endtask

    task automatic read_one();
        u_if.ReadEn = 1'b1;
        tick();
        idle();
    endtask

    // Read the head word with the given codeword bits inverted on the way out.
    task automatic read_corrupt(input logic [ECC_WIDTH-1:0] m);
        cw   = dut.w_rd_cw;
        mask = m;
        force dut.w_rd_cw = cw ^ mask;
        u_if.ReadEn = 1'b1;
        tick();
        release dut.w_rd_cw;
        idle();
    endtask

    function automatic logic [2:0] flags();
        return {u_if.Empty_, u_if.HalfFull_, u_if.Full_};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        vecs[0] = '{1'b1, 1'b0, VA,    3'b111, 64'h0};
        vecs[1] = '{1'b1, 1'b0, VB,    3'b111, 64'h0};
        vecs[2] = '{1'b0, 1'b1, 64'h0, 3'b111, VA};
        vecs[3] = '{1'b1, 1'b1, VC,    3'b111, VB};
        vecs[4] = '{1'b0, 1'b1, 64'h0, 3'b011, VC};
        vecs[5] = '{1'b0, 1'b1, 64'h0, 3'b011, VC};
        vecs[6] = '{1'b1, 1'b1, VD,    3'b111, VC};
        vecs[7] = '{1'b0, 1'b1, 64'h0, 3'b011, VD};
        vecs[8] = '{1'b0, 1'b0, 64'h0, 3'b011, VD};

        do_reset();
        chk("reset_flags",  64'(flags()), 64'(3'b011));
        chk("reset_dout",   u_if.DataOut, 64'h0);
        chk("reset_error",  64'(u_if.Error), 64'h0);
        chk("reset_sm",     64'(u_if.sm_error), 64'h0);
        chk("reset_syn",    64'(u_if.is_parity_diff), 64'h0);

        for (int i = 0; i < 9; i++) begin
            u_if.WriteEn = vecs[i].we;
            u_if.ReadEn  = vecs[i].re;
            u_if.DataIn  = vecs[i].din;
            tick();
            chk($sformatf("vec%0d_flags", i), 64'(flags()), 64'(vecs[i].flags));
            chk($sformatf("vec%0d_dout", i), u_if.DataOut, vecs[i].dout);
            chk($sformatf("vec%0d_ecc", i),
                64'({u_if.error_flag, u_if.correct, u_if.is_parity_diff}), 64'h0);
        end
        idle();

        // Fill to full, overflow attempt, drain in order.
        for (int i = 0; i < 128; i++) begin
            write_one(64'(i));
            chk($sformatf("fill%0d_half", i), 64'(u_if.HalfFull_), (i >= 63) ? 64'h0 : 64'h1);
            chk($sformatf("fill%0d_full", i), 64'(u_if.Full_), (i == 127) ? 64'h0 : 64'h1);
        end
        write_one(64'h0000_0000_0000_DEAD);
        chk("overflow_full", 64'(u_if.Full_), 64'h0);
        for (int i = 0; i < 128; i++) begin
            read_one();
            chk($sformatf("drain%0d", i), u_if.DataOut, 64'(i));
        end
        chk("drain_flags", 64'(flags()), 64'(3'b011));
        read_one();
        chk("underflow_hold", u_if.DataOut, 64'd127);
        chk("underflow_flags", 64'(flags()), 64'(3'b011));

        // Streaming through a full FIFO, then drain across the pointer wrap.
        for (int i = 0; i < 128; i++) write_one(64'h200 + 64'(i));
        chk("stream_full", 64'(flags()), 64'(3'b100));
        for (int k = 0; k < 10; k++) begin
            u_if.WriteEn = 1'b1;
            u_if.ReadEn  = 1'b1;
            u_if.DataIn  = 64'd1000 + 64'(k);
            tick();
            chk($sformatf("stream%0d_dout", k), u_if.DataOut, 64'h200 + 64'(k));
            chk($sformatf("stream%0d_full", k), 64'(u_if.Full_), 64'h0);
        end
        idle();
        for (int i = 10; i < 128; i++) begin
            read_one();
            chk($sformatf("sdrain%0d", i), u_if.DataOut, 64'h200 + 64'(i));
        end
        for (int k = 0; k < 10; k++) begin
            read_one();
            chk($sformatf("sdrain_new%0d", k), u_if.DataOut, 64'd1000 + 64'(k));
        end
        chk("stream_empty", 64'(flags()), 64'(3'b011));
        chk("stream_sm", 64'(u_if.sm_error), 64'h0);

        // Single-bit error at data position 5.
        write_one(VA);
        read_corrupt(ECC_WIDTH'(1) << 4);
        chk("sbe5_dout",    u_if.DataOut, VA);
        chk("sbe5_correct", 64'(u_if.correct), 64'h1);
        chk("sbe5_syn",     64'(u_if.is_parity_diff), 64'd5);
        chk("sbe5_error",   64'(u_if.Error), 64'h0);

        // Single-bit errors at the lowest and highest codeword positions.
        write_one(VD);
        read_corrupt(ECC_WIDTH'(1));
        chk("sbe1_dout", u_if.DataOut, VD);
        chk("sbe1_syn",  64'({u_if.correct, u_if.is_parity_diff}), 64'({1'b1, 7'd1}));
        write_one(VA);
        read_corrupt(ECC_WIDTH'(1) << 70);
        chk("sbe71_dout", u_if.DataOut, VA);
        chk("sbe71_syn",  64'({u_if.correct, u_if.is_parity_diff}), 64'({1'b1, 7'd71}));

        // Positions 64 and 8 together give syndrome 72: out of range, uncorrectable.
        write_one(VB);
        read_corrupt((ECC_WIDTH'(1) << 63) | (ECC_WIDTH'(1) << 7));
        chk("dbe_dout",    u_if.DataOut, VB);
        chk("dbe_eflag",   64'(u_if.error_flag), 64'h1);
        chk("dbe_correct", 64'(u_if.correct), 64'h0);
        chk("dbe_syn",     64'(u_if.is_parity_diff), 64'd72);
        chk("dbe_error",   64'(u_if.Error), 64'h1);

        write_one(VC);
        read_one();
        chk("clean_dout",  u_if.DataOut, VC);
        chk("clean_ecc",   64'({u_if.error_flag, u_if.correct, u_if.is_parity_diff}), 64'h0);
        chk("clean_error", 64'(u_if.Error), 64'h0);

        // Monitor: a wrong Full_ at count 3 latches sm_error until reset.
        write_one(64'd1);
        write_one(64'd2);
        write_one(64'd3);
        chk("sm_pre", 64'(u_if.sm_error), 64'h0);
        force u_if.Full_ = 1'b0;
        tick();
        chk("sm_set",       64'(u_if.sm_error), 64'h1);
        chk("sm_set_error", 64'(u_if.Error), 64'h1);
        release u_if.Full_;
        tick();
        tick();
        chk("sm_sticky",    64'(u_if.sm_error), 64'h1);
        do_reset();
        chk("sm_cleared",   64'(u_if.sm_error), 64'h0);
        chk("sm_clr_error", 64'(u_if.Error), 64'h0);
        chk("rst_discard",  64'(flags()), 64'(3'b011));
        read_one();
        chk("rst_discard_dout", u_if.DataOut, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
